fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 22 ++
 rtl/fetch_queue.sv | 103 ++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory read port, redirect input and the
// queue's output handshake. master = fetch_queue side, slave = IM/consumer side.
interface fetch_queue_if;
  logic        im_ce;
  logic [13:0] im_addr;
  logic [31:0] im_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output im_ce, im_addr, out_valid, out_instr, out_pc,
    input  im_rdata, redirect, redirect_pc, out_ready
  );
  modport slave (
    input  im_ce, im_addr, out_valid, out_instr, out_pc,
    output im_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues IM reads ahead of the consumer and buffers
// up to DEPTH instructions. Define FETCH_QUEUE_BYPASS_EN for the empty-queue bypass.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = DEPTH[AW+1:0];
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [31:0]   fetch_pc, req_pc;
  logic          pending;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];

  logic [AW+1:0] occ;
  logic [31:0]   redir_pc;
  logic          issue, resp_ok, byp, push, pop, empty;

  // Reservation counts the in-flight read, so a push always has room.
  assign occ      = {1'b0, count} + {{(AW+1){1'b0}}, pending};
  assign issue    = (state == RUN) && !bus.redirect && (occ < DEPTH_W);
  assign resp_ok  = pending && !bus.redirect;
  assign empty    = (count == '0);
  assign redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = resp_ok && empty;
`else
  assign byp = 1'b0;
`endif

  assign push = resp_ok && !(byp && bus.out_ready);
  assign pop  = !empty && bus.out_ready;

  assign bus.im_ce   = issue;
  assign bus.im_addr = fetch_pc[15:2];

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_instr = '0;
    bus.out_pc    = '0;
    if (!empty) begin
      bus.out_valid = 1'b1;
      bus.out_instr = mem_instr[rd_ptr];
      bus.out_pc    = mem_pc[rd_ptr];
    end else if (byp) begin
      bus.out_valid = 1'b1;
      bus.out_instr = bus.im_rdata;
      bus.out_pc    = req_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      pending  <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state   <= RUN;
      pending <= issue;
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      // Redirect overrides any concurrent push/pop and drops the pending response.
      if (bus.redirect) begin
        fetch_pc <= redir_pc;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_instr[wr_ptr] <= bus.im_rdata;
      mem_pc[wr_ptr]    <= req_pc;
    end
  end
endmodule
